// File: rtl/result_arbiter_pkg.sv
// Shared motion-estimation constants and types used by the result arbiter.
package result_arbiter_pkg;

    localparam int SAD_W          = 14;
    localparam int VEC_W          = 4;
    localparam int SER_CYCLES_DEF = 16;

    typedef logic [SAD_W-1:0] sad_t;
    typedef logic [VEC_W-1:0] vec_t;

    typedef struct packed {
        sad_t sad;
        vec_t mvx;
        vec_t mvy;
    } me_result_t;

    // Occupancy counter width; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/result_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping.
module rr_pick
    import result_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   winner,
    output logic             valid
);

    localparam int unsigned NR = N_REQ;

    int unsigned idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = (32'(ptr) + i) % NR;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/result_arbiter.sv
// Round-robin arbiter granting one ME engine at a time to a shared result serializer.
module result_arbiter
    import result_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int SER_CYCLES = SER_CYCLES_DEF,
    parameter int IDW        = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SAD_W-1:0] sad_in,
    input  logic [N_REQ*VEC_W-1:0] mvx_in,
    input  logic [N_REQ*VEC_W-1:0] mvy_in,
    output logic [N_REQ-1:0]       ack,
    output logic                   ser_en,
    output logic [SAD_W-1:0]       ser_sad,
    output logic [VEC_W-1:0]       ser_x,
    output logic [VEC_W-1:0]       ser_y,
    output logic [IDW-1:0]         ser_id,
    output logic                   busy
);

    localparam int CW = cnt_width(SER_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic [IDW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [N_REQ-1:0] ack_q,     ack_d;
    logic             ser_en_q,  ser_en_d;
    logic             busy_q,    busy_d;
    logic [IDW-1:0]   ser_id_q,  ser_id_d;
    me_result_t       res_q,     res_d;

    logic [IDW-1:0]   pick_id;
    logic             pick_valid;
    me_result_t       pick_res;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_res.sad = sad_in[int'(pick_id)*SAD_W +: SAD_W];
        pick_res.mvx = mvx_in[int'(pick_id)*VEC_W +: VEC_W];
        pick_res.mvy = mvy_in[int'(pick_id)*VEC_W +: VEC_W];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        ser_en_d = 1'b0;
        busy_d   = busy_q;
        ser_id_d = ser_id_q;
        res_d    = res_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d         = ST_WAIT;
                    ack_d[pick_id]  = 1'b1;
                    ser_en_d        = 1'b1;
                    busy_d          = 1'b1;
                    cnt_d           = CW'(SER_CYCLES - 1);
                    ser_id_d        = pick_id;
                    res_d           = pick_res;
                    rr_ptr_d        = (int'(pick_id) == N_REQ - 1) ? '0 : pick_id + IDW'(1);
                end
            end
            ST_WAIT: begin
                // Requests are deliberately not sampled while the serializer is occupied.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            ser_en_q <= 1'b0;
            busy_q   <= 1'b0;
            ser_id_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            ser_en_q <= ser_en_d;
            busy_q   <= busy_d;
            ser_id_q <= ser_id_d;
            res_q    <= res_d;
        end
    end

    assign ack     = ack_q;
    assign ser_en  = ser_en_q;
    assign busy    = busy_q;
    assign ser_sad = res_q.sad;
    assign ser_x   = res_q.mvx;
    assign ser_y   = res_q.mvy;
    assign ser_id  = ser_id_q;

endmodule

// File: tb/tb_result_arbiter.sv
// Scoreboard bench for result_arbiter: timeline reference model feeds queues, negedge monitor checks.
module tb_result_arbiter;
    import result_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int SC = 16;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req;
    logic [N*SAD_W-1:0]   sad_in;
    logic [N*VEC_W-1:0]   mvx_in;
    logic [N*VEC_W-1:0]   mvy_in;
    logic [N-1:0]         ack;
    logic                 ser_en;
    logic [SAD_W-1:0]     ser_sad;
    logic [VEC_W-1:0]     ser_x;
    logic [VEC_W-1:0]     ser_y;
    logic [IW-1:0]        ser_id;
    logic                 busy;

    result_arbiter #(
        .N_REQ      (N),
        .SER_CYCLES (SC),
        .IDW        (IW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .sad_in  (sad_in),
        .mvx_in  (mvx_in),
        .mvy_in  (mvy_in),
        .ack     (ack),
        .ser_en  (ser_en),
        .ser_sad (ser_sad),
        .ser_x   (ser_x),
        .ser_y   (ser_y),
        .ser_id  (ser_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int           e;
        logic [N-1:0] ack;
    } grant_t;

    typedef struct {
        int               e;
        logic             busy;
        logic [SAD_W-1:0] sad;
        logic [VEC_W-1:0] x;
        logic [VEC_W-1:0] y;
        logic [IW-1:0]    id;
    } stat_t;

    grant_t gq[$];
    stat_t  sq[$];

    int total = 0;
    int bad   = 0;

    // Reference model: a grant blocks new grants for SC+1 edges; ptr follows last winner.
    int               m_ptr  = 0;
    int               m_last = -1000;
    logic [SAD_W-1:0] h_sad  = '0;
    logic [VEC_W-1:0] h_x    = '0;
    logic [VEC_W-1:0] h_y    = '0;
    logic [IW-1:0]    h_id   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic step(input logic r_n, input logic [N-1:0] rq, input bit rnd);
        int     e;
        int     w;
        grant_t g;
        stat_t  s;
        rst_n = r_n;
        req   = rq;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                sad_in[i*SAD_W +: SAD_W] = SAD_W'($urandom);
                mvx_in[i*VEC_W +: VEC_W] = VEC_W'($urandom);
                mvy_in[i*VEC_W +: VEC_W] = VEC_W'($urandom);
            end
        end
        e = edge_cnt + 1;
        if (!r_n) begin
            m_ptr  = 0;
            m_last = -1000;
            h_sad  = '0;
            h_x    = '0;
            h_y    = '0;
            h_id   = '0;
        end else if (rq != '0 && e >= m_last + SC + 1) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            g.e   = e;
            g.ack = N'(1) << w;
            gq.push_back(g);
            h_sad  = sad_in[w*SAD_W +: SAD_W];
            h_x    = mvx_in[w*VEC_W +: VEC_W];
            h_y    = mvy_in[w*VEC_W +: VEC_W];
            h_id   = IW'(w);
            m_last = e;
            m_ptr  = (w + 1) % N;
        end
        s.e    = e;
        s.busy = r_n && (e >= m_last) && (e < m_last + SC);
        s.sad  = h_sad;
        s.x    = h_x;
        s.y    = h_y;
        s.id   = h_id;
        sq.push_back(s);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        grant_t g;
        stat_t  s;
        if (sq.size() > 0 && sq[0].e == edge_cnt) begin
            s = sq.pop_front();
            check("busy",    32'(busy),    32'(s.busy));
            check("ser_sad", 32'(ser_sad), 32'(s.sad));
            check("ser_x",   32'(ser_x),   32'(s.x));
            check("ser_y",   32'(ser_y),   32'(s.y));
            check("ser_id",  32'(ser_id),  32'(s.id));
        end
        if (ser_en !== 1'b0 || ack !== '0) begin
            if (gq.size() > 0 && gq[0].e == edge_cnt) begin
                g = gq.pop_front();
                check("ack",    32'(ack),    32'(g.ack));
                check("ser_en", 32'(ser_en), 32'(1));
            end else begin
                check("unexpected_ack",    32'(ack),    32'(0));
                check("unexpected_ser_en", 32'(ser_en), 32'(0));
            end
        end else if (gq.size() > 0 && gq[0].e <= edge_cnt) begin
            g = gq.pop_front();
            check("missing_grant", 32'(ack), 32'(g.ack));
        end
    end

    initial begin
        int guard;
        logic [N-1:0] rq;

        // Reset, then idle with no requests.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, '0, 1'b1);

        // Single directed request from engine 2.
        sad_in = '0; mvx_in = '0; mvy_in = '0;
        sad_in[2*SAD_W +: SAD_W] = 14'd300;
        mvx_in[2*VEC_W +: VEC_W] = 4'd3;
        mvy_in[2*VEC_W +: VEC_W] = 4'b1110;
        step(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, '0, 1'b0);

        // All engines requesting continuously: rotation and spacing.
        for (int i = 0; i < 5 * (SC + 1) + 3; i++) step(1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, '0, 1'b1);

        // Engine 0 keeps requesting through the occupancy window.
        for (int i = 0; i < 2 * (SC + 1) + 5; i++) step(1'b1, 4'b0001, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, '0, 1'b1);

        // Reset mid-window with the counter at 8.
        step(1'b1, 4'b1010, 1'b1);
        guard = 0;
        while (edge_cnt + 1 < m_last + 8 && guard < 40) begin
            step(1'b1, 4'b1010, 1'b1);
            guard++;
        end
        step(1'b0, 4'b1010, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1010, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, '0, 1'b1);

        // Short pulse from engine 3 while busy is never granted.
        step(1'b1, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b1);
        step(1'b1, 4'b1000, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, '0, 1'b1);

        // Randomized traffic with occasional resets.
        rq = '0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom);
            step(($urandom_range(0, 99) != 0), rq, 1'b1);
        end

        for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b1);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(gq.size() + sq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
